// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file (reg_file_mp).
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package reg_file_pkg;

  typedef enum logic [0:0] {
    CLR_IDLE,
    CLR_SWEEP
  } clr_state_t;

  localparam int unsigned ZERO_REG     = 0;
  localparam int unsigned MAX_WR_PORTS = 8;

  // Highest set bit of the match vector, or -1 when no port matches.
  function automatic int wr_prio_sel(input logic [MAX_WR_PORTS-1:0] match);
    int sel;
    sel = -1;
    for (int p = 0; p < int'(MAX_WR_PORTS); p++) begin
      if (match[p]) sel = p;
    end
    return sel;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-facing bus of reg_file_mp; REGFILE_SCOREBOARD_EN adds the busy-tracking signals.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

interface reg_file_mp_if #(
  parameter int unsigned DATA_W   = `WORD_SIZE,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2
);

  logic [NUM_WR-1:0]             wr_en;
  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr;
  logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic                          clr_req;
  logic                          clr_busy;
  logic                          clr_done;
`ifdef REGFILE_SCOREBOARD_EN
  logic [NUM_WR-1:0]             alloc_en;
  logic [NUM_WR-1:0][ADDR_W-1:0] alloc_addr;
  logic [NUM_RD-1:0]             rd_busy;
`endif

  modport master (
`ifdef REGFILE_SCOREBOARD_EN
    output alloc_en, alloc_addr,
    input  rd_busy,
`endif
    output wr_en, wr_addr, wr_data, rd_addr, clr_req,
    input  rd_data, clr_busy, clr_done
  );

  modport slave (
`ifdef REGFILE_SCOREBOARD_EN
    input  alloc_en, alloc_addr,
    output rd_busy,
`endif
    input  wr_en, wr_addr, wr_data, rd_addr, clr_req,
    output rd_data, clr_busy, clr_done
  );

endinterface

// File: rtl/reg_file_wr_arb.sv
// Resolves which write port (if any) targets addr; the highest-indexed enabled port wins.

module reg_file_wr_arb
  import reg_file_pkg::*;
#(
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic [ADDR_W-1:0]             addr,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0] wr_data,
  output logic                          hit,
  output logic [DATA_W-1:0]             data
);

  logic [MAX_WR_PORTS-1:0] match;
  int                      sel;

  always_comb begin
    match = '0;
    for (int p = 0; p < int'(NUM_WR); p++) begin
      match[p] = wr_en[p] && (wr_addr[p] == addr) && (addr != ADDR_W'(ZERO_REG));
    end
    sel  = wr_prio_sel(match);
    hit  = (sel >= 0);
    data = '0;
    for (int p = 0; p < int'(NUM_WR); p++) begin
      if (p == sel) data = wr_data[p];
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with same-cycle bypass and a sequential clear sweep.
// Define REGFILE_SCOREBOARD_EN to add per-register busy tracking (alloc_en/alloc_addr/rd_busy).
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = `WORD_SIZE,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned BYPASS   = 1
) (
  input  logic         clk,
  input  logic         reset,
  reg_file_mp_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  clr_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                done_q, done_d;
  logic [NUM_WR-1:0]   wr_en_eff;
  logic [DATA_W-1:0]   regs_q  [NUM_REGS];
  logic [NUM_REGS-1:0] st_hit;
  logic [DATA_W-1:0]   st_data [NUM_REGS];
  logic [NUM_RD-1:0]   rd_hit;
  logic [DATA_W-1:0]   rd_fwd  [NUM_RD];
  logic [NUM_RD-1:0]   rd_valid;

  // External writes (and hence bypass) are locked out while the sweep runs.
  assign wr_en_eff = (state_q == CLR_IDLE) ? bus.wr_en : '0;

  assign st_hit[0]  = 1'b0;
  assign st_data[0] = '0;

  for (genvar r = 1; r < int'(NUM_REGS); r++) begin : g_st_arb
    reg_file_wr_arb #(
      .NUM_WR (NUM_WR),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_st_arb (
      .addr    (ADDR_W'(r)),
      .wr_en   (wr_en_eff),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .hit     (st_hit[r]),
      .data    (st_data[r])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < int'(NUM_REGS); r++) regs_q[r] <= '0;
    end else begin
      for (int r = 1; r < int'(NUM_REGS); r++) begin
        if (state_q == CLR_SWEEP && idx_q == ADDR_W'(r)) begin
          regs_q[r] <= '0;
        end else if (st_hit[r]) begin
          regs_q[r] <= st_data[r];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      CLR_IDLE: begin
        if (bus.clr_req) begin
          state_d = CLR_SWEEP;
          idx_d   = ADDR_W'(1);
        end
      end
      CLR_SWEEP: begin
        if (idx_q == LAST_IDX) begin
          state_d = CLR_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLR_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign bus.clr_busy = (state_q == CLR_SWEEP);
  assign bus.clr_done = done_q;

`ifdef REGFILE_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy_q, busy_d, alloc_hit;

  always_comb begin
    alloc_hit = '0;
    for (int r = 1; r < int'(NUM_REGS); r++) begin
      for (int p = 0; p < int'(NUM_WR); p++) begin
        if (bus.alloc_en[p] && bus.alloc_addr[p] == ADDR_W'(r)) alloc_hit[r] = 1'b1;
      end
    end
  end

  // Allocation beats a same-cycle committed write to the same register.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < int'(NUM_REGS); r++) begin
      if (alloc_hit[r]) begin
        busy_d[r] = 1'b1;
      end else if (st_hit[r]) begin
        busy_d[r] = 1'b0;
      end
    end
    if (state_q == CLR_SWEEP) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end
`endif

  for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
    reg_file_wr_arb #(
      .NUM_WR (NUM_WR),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_rd_arb (
      .addr    (bus.rd_addr[i]),
      .wr_en   (wr_en_eff),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .hit     (rd_hit[i]),
      .data    (rd_fwd[i])
    );

    assign rd_valid[i] = (bus.rd_addr[i] != ADDR_W'(ZERO_REG)) &&
                         (32'(bus.rd_addr[i]) < NUM_REGS);

    assign bus.rd_data[i] = !rd_valid[i]                ? '0 :
                            (BYPASS != 0 && rd_hit[i]) ? rd_fwd[i] :
                                                         regs_q[bus.rd_addr[i]];
`ifdef REGFILE_SCOREBOARD_EN
    assign bus.rd_busy[i] = rd_valid[i] && !(BYPASS != 0 && rd_hit[i]) &&
                            busy_q[bus.rd_addr[i]];
`endif
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a bypassing and a non-bypassing instance share stimulus and one model.

module tb_reg_file_mp;

  localparam int unsigned DW  = 32;
  localparam int unsigned NR  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned NRD = 2;
  localparam int unsigned NWR = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  reg_file_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR)) bus ();
  reg_file_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR)) bus_nb ();

  reg_file_mp #(
    .DATA_W (DW), .NUM_REGS (NR), .ADDR_W (AW), .NUM_RD (NRD), .NUM_WR (NWR), .BYPASS (1)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  reg_file_mp #(
    .DATA_W (DW), .NUM_REGS (NR), .ADDR_W (AW), .NUM_RD (NRD), .NUM_WR (NWR), .BYPASS (0)
  ) u_dut_nb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nb)
  );

  assign bus_nb.wr_en   = bus.wr_en;
  assign bus_nb.wr_addr = bus.wr_addr;
  assign bus_nb.wr_data = bus.wr_data;
  assign bus_nb.rd_addr = bus.rd_addr;
  assign bus_nb.clr_req = bus.clr_req;
`ifdef REGFILE_SCOREBOARD_EN
  assign bus_nb.alloc_en   = bus.alloc_en;
  assign bus_nb.alloc_addr = bus.alloc_addr;
`endif

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Architectural model: contents, busy bits, and sweep as "busy for NUM_REGS-1 cycles,
  // then everything is zero and done pulses once".
  logic [DW-1:0] m_mem [NR];
  logic [NR-1:0] m_sb;
  bit            m_busy;
  bit            m_done;
  int            m_left;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(NR); k++) m_mem[k] = '0;
      m_sb   = '0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_sb = '0;
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          for (int k = 0; k < int'(NR); k++) m_mem[k] = '0;
        end
      end else begin
        for (int p = 0; p < int'(NWR); p++) begin
          if (bus.wr_en[p] && bus.wr_addr[p] != '0) begin
            m_mem[bus.wr_addr[p]] = bus.wr_data[p];
            m_sb[bus.wr_addr[p]]  = 1'b0;
          end
        end
`ifdef REGFILE_SCOREBOARD_EN
        for (int p = 0; p < int'(NWR); p++) begin
          if (bus.alloc_en[p] && bus.alloc_addr[p] != '0) m_sb[bus.alloc_addr[p]] = 1'b1;
        end
`endif
        if (bus.clr_req) begin
          m_busy = 1'b1;
          m_left = NR - 1;
        end
      end
    end
  end

  function automatic bit fwd_hit(input logic [AW-1:0] a);
    bit h;
    h = 1'b0;
    if (a != '0 && !m_busy) begin
      for (int p = 0; p < int'(NWR); p++) if (bus.wr_en[p] && bus.wr_addr[p] == a) h = 1'b1;
    end
    return h;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    logic [DW-1:0] v;
    if (a == '0) return '0;
    v = m_mem[a];
    if (byp && fwd_hit(a)) begin
      for (int p = 0; p < int'(NWR); p++) if (bus.wr_en[p] && bus.wr_addr[p] == a) v = bus.wr_data[p];
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("clr_busy", 64'(bus.clr_busy), 64'(m_busy));
      chk("clr_done", 64'(bus.clr_done), 64'(m_done));
      chk("clr_busy_nb", 64'(bus_nb.clr_busy), 64'(m_busy));
      if (!m_busy) begin
        for (int i = 0; i < int'(NRD); i++) begin
          chk("rd_data", 64'(bus.rd_data[i]), 64'(exp_rd(bus.rd_addr[i], 1'b1)));
          chk("rd_data_nb", 64'(bus_nb.rd_data[i]), 64'(exp_rd(bus.rd_addr[i], 1'b0)));
`ifdef REGFILE_SCOREBOARD_EN
          chk("rd_busy", 64'(bus.rd_busy[i]),
              64'(m_sb[bus.rd_addr[i]] && !fwd_hit(bus.rd_addr[i])));
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en   = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    bus.clr_req = 1'b0;
`ifdef REGFILE_SCOREBOARD_EN
    bus.alloc_en   = '0;
    bus.alloc_addr = '0;
`endif
  endtask

  int n;

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.clr_busy), 64'd0);
    chk("rst_done", 64'(bus.clr_done), 64'd0);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Every address reads zero after reset.
    for (int a = 0; a < int'(NR); a++) begin
      bus.rd_addr[0] = AW'(a);
      bus.rd_addr[1] = AW'(NR - 1 - a);
      #1;
      chk("rst_rd0", 64'(bus.rd_data[0]), 64'd0);
      chk("rst_rd1", 64'(bus.rd_data[1]), 64'd0);
    end
    step();

    // Same-cycle bypass vs stored-only read.
    bus.wr_en = 2'b01; bus.wr_addr[0] = 5; bus.wr_data[0] = 32'hDEADBEEF; bus.rd_addr[0] = 5;
    #1;
    chk("byp_same", 64'(bus.rd_data[0]), 64'hDEADBEEF);
    chk("nobyp_same", 64'(bus_nb.rd_data[0]), 64'd0);
    step();
    bus.wr_en = '0;
    #1;
    chk("nobyp_next", 64'(bus_nb.rd_data[0]), 64'hDEADBEEF);

    // Write conflict: port 1 wins.
    bus.wr_en = 2'b11; bus.wr_addr[0] = 7; bus.wr_addr[1] = 7;
    bus.wr_data[0] = 32'h11111111; bus.wr_data[1] = 32'h22222222;
    bus.rd_addr[0] = 7; bus.rd_addr[1] = 7;
    #1;
    chk("conf_byp0", 64'(bus.rd_data[0]), 64'h22222222);
    chk("conf_byp1", 64'(bus.rd_data[1]), 64'h22222222);
    step();
    bus.wr_en = '0;
    #1;
    chk("conf_store", 64'(bus.rd_data[0]), 64'h22222222);
    chk("conf_store_nb", 64'(bus_nb.rd_data[1]), 64'h22222222);

    // r0 is hardwired.
    bus.wr_en = 2'b01; bus.wr_addr[0] = 0; bus.wr_data[0] = 32'hFFFFFFFF; bus.rd_addr[0] = 0;
    #1;
    chk("r0_byp", 64'(bus.rd_data[0]), 64'd0);
    step();
    bus.wr_en = '0;
    #1;
    chk("r0_store", 64'(bus.rd_data[0]), 64'd0);

    // Fill r1..r31 with their index.
    for (int a = 1; a < int'(NR); a += 2) begin
      bus.wr_en      = {(a + 1 < int'(NR)), 1'b1};
      bus.wr_addr[0] = AW'(a);     bus.wr_data[0] = DW'(a);
      bus.wr_addr[1] = AW'(a + 1); bus.wr_data[1] = DW'(a + 1);
      step();
    end
    bus.wr_en = '0;
    bus.rd_addr[1] = 20;
    #1;
    chk("fill_r20", 64'(bus.rd_data[1]), 64'd20);

    // Clear sweep with a write attempt and a repeated request mid-sweep.
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    chk("sweep_start", 64'(bus.clr_busy), 64'd1);
    n = 0;
    while (bus.clr_busy && n < 100) begin
      n++;
      bus.wr_en = (n == 5) ? 2'b01 : 2'b00;
      bus.wr_addr[0] = 3; bus.wr_data[0] = 5;
      bus.clr_req = (n == 10);
      step();
    end
    bus.wr_en = '0; bus.clr_req = 1'b0;
    chk("sweep_len", 64'(n), 64'd31);
    chk("sweep_done", 64'(bus.clr_done), 64'd1);
    step();
    chk("sweep_done_off", 64'(bus.clr_done), 64'd0);
    for (int a = 1; a < int'(NR); a++) begin
      bus.rd_addr[0] = AW'(a);
      #1;
      chk("swept_zero", 64'(bus.rd_data[0]), 64'd0);
    end
    bus.rd_addr[0] = 3;
    #1;
    chk("r3_not5", 64'(bus.rd_data[0]), 64'd0);
    step();

    // Write alongside clr_req commits, then reset aborts the sweep at cycle 10.
    bus.wr_en = 2'b01; bus.wr_addr[0] = 12; bus.wr_data[0] = 32'h55; bus.clr_req = 1'b1;
    bus.rd_addr[0] = 12;
    step();
    bus.wr_en = '0; bus.clr_req = 1'b0;
    chk("req_wr_commit", 64'(bus.rd_data[0]), 64'h55);
    repeat (9) step();
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.clr_busy), 64'd0);
    chk("abort_done", 64'(bus.clr_done), 64'd0);
    chk("abort_r12", 64'(bus.rd_data[0]), 64'd0);
    step();
    reset = 1'b0;
    repeat (3) begin
      step();
      chk("abort_no_done", 64'(bus.clr_done), 64'd0);
    end
    bus.wr_en = 2'b10; bus.wr_addr[1] = 9; bus.wr_data[1] = 32'hA; bus.rd_addr[1] = 9;
    step();
    bus.wr_en = '0;
    #1;
    chk("post_abort_r9", 64'(bus.rd_data[1]), 64'hA);
    chk("post_abort_r9_nb", 64'(bus_nb.rd_data[1]), 64'hA);

`ifdef REGFILE_SCOREBOARD_EN
    bus.alloc_en = 2'b01; bus.alloc_addr[0] = 4; bus.rd_addr[0] = 4;
    step();
    bus.alloc_en = '0;
    #1;
    chk("sb_alloc", 64'(bus.rd_busy[0]), 64'd1);
    bus.alloc_en = 2'b10; bus.alloc_addr[1] = 4;
    bus.wr_en = 2'b01; bus.wr_addr[0] = 4; bus.wr_data[0] = 32'h3;
    #1;
    chk("sb_byp_busy", 64'(bus.rd_busy[0]), 64'd0);
    step();
    bus.alloc_en = '0; bus.wr_en = '0;
    #1;
    chk("sb_alloc_wins", 64'(bus.rd_busy[0]), 64'd1);
    chk("sb_data3", 64'(bus.rd_data[0]), 64'h3);
    bus.wr_en = 2'b01; bus.wr_data[0] = 32'h9;
    step();
    bus.wr_en = '0;
    #1;
    chk("sb_release", 64'(bus.rd_busy[0]), 64'd0);
    chk("sb_data9", 64'(bus.rd_data[0]), 64'h9);
    bus.alloc_en = 2'b01; bus.alloc_addr[0] = 0; bus.rd_addr[0] = 0;
    step();
    bus.alloc_en = '0;
    #1;
    chk("sb_r0", 64'(bus.rd_busy[0]), 64'd0);
    bus.alloc_en = 2'b01; bus.alloc_addr[0] = 6; bus.rd_addr[1] = 6;
    step();
    bus.alloc_en = '0; bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    step();
    n = 0;
    while (bus.clr_busy && n < 100) begin
      n++;
      step();
    end
    chk("sb_sweep_len_bound", 64'(n < 100), 64'd1);
    chk("sb_swept", 64'(bus.rd_busy[1]), 64'd0);
`endif

    step();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
